mpu_wb_ram_bridge: RTL and testbench
====================================

// Module: mpu_wb_ram_bridge
// PURPOSE
//  Registered Wishbone slave to a BANKS-way word-interleaved set of byte-lane RAMs; MPU memory port.
//  Word w = wb_adr_i[WB_ADR_W-1:2] lives in bank (w mod BANKS) at row (w / BANKS).
//  Adds single-cycle registered ack, pipelined incrementing read bursts, byte-lane writes, optional wide fetch window.
// PARAMETERS
//  DATA_W      32  Wishbone/bank data width; multiple of 8
//  BANKS       2   number of interleaved banks; power of 2, >= 2
//  BANK_ADR_W  12  row address width per bank
//  WB_ADR_W    15  byte address width; must equal BANK_ADR_W + log2(BANKS) + 2
// PORTS
//  sys_clk     in   1                   clock, all state on rising edge
//  sys_rst     in   1                   synchronous, active-high reset
//  wb_adr_i    in   WB_ADR_W            byte address; bits [1:0] ignored
//  wb_dat_i    in   DATA_W              write data
//  wb_dat_o    out  DATA_W              read data, valid when wb_ack_o
//  wb_sel_i    in   DATA_W/8            byte-lane selects
//  wb_we_i     in   1                   write enable
//  wb_cyc_i    in   1                   cycle
//  wb_stb_i    in   1                   strobe
//  wb_cti_i    in   3                   000 classic, 010 incrementing, 111 end of burst
//  wb_ack_o    out  1                   acknowledge
//  ram_adr_o   out  BANKS*BANK_ADR_W    row address, bank b in slice b
//  ram_dat_o   out  BANKS*DATA_W        write data, wb_dat_i replicated into every bank
//  ram_dat_i   in   BANKS*DATA_W        bank read data, synchronous RAM, 1-cycle latency
//  ram_we_o    out  BANKS*DATA_W/8      per-bank byte write enables
// BEHAVIOUR
//  Reset: state IDLE, wb_ack_o=0, ram_we_o=0, burst counter=0, bank-select reg=0 (win_valid_o=0 if built).
//  wb_ack_o = ack_q & wb_cyc_i & wb_stb_i; never asserted without a live strobe.
//  IDLE: on cyc&stb&!ack_q, drive every bank's row from wb_adr_i and register the target bank index.
//   write: ram_we_o for target bank = wb_sel_i, all others 0, this cycle only; ack_q<=1; next state ACKW.
//   read, cti!=010: ack_q<=1; next ACKR. Read, cti=010: ack_q<=1; counter<=w+1; next BURST.
//  ACKW/ACKR: ack shown for 1 cycle, ack_q<=0, back to IDLE; 2 cycles per classic access; writes never burst.
//  Read data: wb_dat_o = ram_dat_i slice of registered bank index (one-cycle RAM latency covered by ack delay).
//  BURST: rows driven from counter (not wb_adr_i); ack each cycle while cyc&stb; counter+1 per ack.
//   ack with cti=111 -> IDLE, ack_q<=0. stb low or cyc low -> IDLE, no ack, counter discarded.
//   wb_adr_i not checked in burst; bte ignored, linear only. Counter wraps mod 2^(WB_ADR_W-2) to row 0 of bank 0.
//  Write enables never asserted outside IDLE; a write strobe in BURST ends the burst (IDLE, then serviced).
//  sys_rst mid-access: ack drops at that edge, no write issued in reset cycle, state IDLE.
// CONFIGURATION
//  MPU_WB_RAM_WINDOW_EN defined: extra port win_dat_o out BANKS*DATA_W and win_valid_o out 1.
//   Bank b row = (w + ((b - w) mod BANKS)) / BANKS, wrapping mod 2^BANK_ADR_W, so the banks hold words w..w+BANKS-1.
//   win_dat_o slice k = word w+k, rotated from ram_dat_i by registered w mod BANKS.
//   win_valid_o = wb_ack_o of a read. Feeds the MPU wide instruction fetch.
//  Undefined: every bank row = w / BANKS (burst: counter / BANKS); no window ports.
// STRUCTURE
//  Package mpu_wb_ram_pkg: state encodings IDLE/ACKR/ACKW/BURST, CTI_CLASSIC/CTI_INCR/CTI_END, clog2 helper.
//  Sub-module mpu_bank_row_calc: combinational word -> per-bank row vector (window or plain); FSM stays in top.
// TESTING
//  Reset then write 0xDEADBEEF @0x0004 sel=1111 -> bank1 row0 we=1111 one cycle, bank0 we=0, ack next cycle.
//  Write 0xAA @0x0008 sel=0001 then read -> 0x000000AA in lane 0, other lanes keep old bytes; bank0 row1.
//  Read burst @0x0000 len 4 (cti 010,010,010,111) -> acks 4 consecutive cycles, words 0..3, then ack=0.
//  Burst from last word 0x7FFC len 2 -> 2nd data = word 0 (bank0 row0); stb dropped mid-burst -> no ack, IDLE.
//  Assert sys_rst during BURST ack cycle -> ack=0 that edge, no ram_we_o, next classic read acks in 1 cycle.
//  WINDOW_EN, BANKS=2, read @0x000C (w=3) -> bank1 row1, bank0 row2; win_dat_o = {word4, word3}, win_valid_o=1.

Source files
------------

// File: rtl/mpu_wb_ram_pkg.sv
// Shared definitions for the MPU Wishbone-to-banked-RAM bridge:
// FSM state encoding, Wishbone cycle-type codes and a log2 helper.
package mpu_wb_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACKR  = 2'd1,
    ACKW  = 2'd2,
    BURST = 2'd3
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int result;
    int rest;
    result = 0;
    rest   = value - 1;
    while (rest > 0) begin
      result = result + 1;
      rest   = rest >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mpu_bank_row_calc.sv
// Word index -> row address for every interleaved bank.
// With MPU_WB_RAM_WINDOW_EN defined, bank b is pointed at the first word
// >= w that lives in bank b, so the banks together hold words w..w+BANKS-1.
// Without it, every bank simply gets row w / BANKS.
module mpu_bank_row_calc
  import mpu_wb_ram_pkg::*;
#(
  parameter int BANKS      = 2,
  parameter int BANK_ADR_W = 12,
  parameter int WORD_W     = 13
) (
  input  logic [WORD_W-1:0]           word,
  output logic [BANKS*BANK_ADR_W-1:0] rows
);

  localparam int BANK_W = clog2(BANKS);

  generate
    for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
`ifdef MPU_WB_RAM_WINDOW_EN
      // Banks below the start bank must read the next row; the add wraps at the top row
      assign rows[gi*BANK_ADR_W +: BANK_ADR_W] =
        word[WORD_W-1:BANK_W] + BANK_ADR_W'(BANK_W'(gi) < word[BANK_W-1:0]);
`else
      // Plain interleave: every bank looks at the same row
      assign rows[gi*BANK_ADR_W +: BANK_ADR_W] = word[WORD_W-1:BANK_W];
`endif
    end
  endgenerate

`ifndef MPU_WB_RAM_WINDOW_EN
  logic unused_bank_bits;
  assign unused_bank_bits = ^word[BANK_W-1:0];
`endif

endmodule

// File: rtl/mpu_wb_ram_bridge.sv
// Registered Wishbone slave onto BANKS word-interleaved byte-lane RAMs.
// Classic accesses take two cycles; incrementing read bursts stream one word
// per cycle from an internal counter. Define MPU_WB_RAM_WINDOW_EN to add the
// wide fetch window ports (win_dat_o / win_valid_o).
module mpu_wb_ram_bridge
  import mpu_wb_ram_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BANKS      = 2,
  parameter int BANK_ADR_W = 12,
  parameter int WB_ADR_W   = 15
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [WB_ADR_W-1:0]          wb_adr_i,
  input  logic [DATA_W-1:0]            wb_dat_i,
  output logic [DATA_W-1:0]            wb_dat_o,
  input  logic [DATA_W/8-1:0]          wb_sel_i,
  input  logic                         wb_we_i,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic [2:0]                   wb_cti_i,
  output logic                         wb_ack_o,
  output logic [BANKS*BANK_ADR_W-1:0]  ram_adr_o,
  output logic [BANKS*DATA_W-1:0]      ram_dat_o,
  input  logic [BANKS*DATA_W-1:0]      ram_dat_i,
  output logic [BANKS*DATA_W/8-1:0]    ram_we_o
`ifdef MPU_WB_RAM_WINDOW_EN
  ,
  output logic [BANKS*DATA_W-1:0]      win_dat_o,
  output logic                         win_valid_o
`endif
);

  localparam int SEL_W  = DATA_W / 8;
  localparam int BANK_W = clog2(BANKS);
  localparam int WORD_W = WB_ADR_W - 2;

  state_t             state_reg;
  logic               ack_reg;
  logic [WORD_W-1:0]  cnt_reg;
  logic [BANK_W-1:0]  bank_reg;

  logic               req;
  logic               wr_fire;
  logic [WORD_W-1:0]  word_cur;
  logic [WORD_W-1:0]  row_word;
  logic               unused_adr_lsb;

  assign req            = wb_cyc_i & wb_stb_i;
  assign word_cur       = wb_adr_i[WB_ADR_W-1:2];
  assign unused_adr_lsb = ^wb_adr_i[1:0];

  // A burst keeps the RAMs busy from the counter; otherwise follow the bus address
  assign row_word = (state_reg == BURST) ? cnt_reg : word_cur;

  mpu_bank_row_calc #(
    .BANKS      (BANKS),
    .BANK_ADR_W (BANK_ADR_W),
    .WORD_W     (WORD_W)
  ) u_row_calc (
    .word (row_word),
    .rows (ram_adr_o)
  );

  // Writes go out only in the accepting IDLE cycle and never while in reset
  assign wr_fire = !sys_rst && (state_reg == IDLE) && req && !ack_reg && wb_we_i;

  generate
    for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
      assign ram_dat_o[gi*DATA_W +: DATA_W] = wb_dat_i;
      assign ram_we_o[gi*SEL_W +: SEL_W] =
        (wr_fire && (word_cur[BANK_W-1:0] == BANK_W'(gi))) ? wb_sel_i : '0;
    end
  endgenerate

  // A write strobe arriving mid-burst is not acked here; it is taken from IDLE
  assign wb_ack_o = ack_reg && req && !((state_reg == BURST) && wb_we_i);
  assign wb_dat_o = ram_dat_i[bank_reg*DATA_W +: DATA_W];

`ifdef MPU_WB_RAM_WINDOW_EN
  // Rotate bank outputs so slice k carries word w+k
  generate
    for (genvar gi = 0; gi < BANKS; gi++) begin : g_win
      logic [BANK_W-1:0] src_idx;
      assign src_idx = bank_reg + BANK_W'(gi);
      assign win_dat_o[gi*DATA_W +: DATA_W] = ram_dat_i[src_idx*DATA_W +: DATA_W];
    end
  endgenerate
  assign win_valid_o = wb_ack_o && (state_reg != ACKW);
`endif

  // Access sequencer: accept, registered ack, burst counter advance
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
      cnt_reg   <= '0;
      bank_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req && !ack_reg) begin
            bank_reg <= word_cur[BANK_W-1:0];
            ack_reg  <= 1'b1;
            if (wb_we_i) begin
              state_reg <= ACKW;
            end else if (wb_cti_i == CTI_INCR) begin
              cnt_reg   <= word_cur + WORD_W'(1);
              state_reg <= BURST;
            end else begin
              state_reg <= ACKR;
            end
          end
        end
        ACKR, ACKW: begin
          ack_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        BURST: begin
          if (!req || wb_we_i || (wb_cti_i == CTI_END)) begin
            ack_reg   <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg  <= cnt_reg + WORD_W'(1);
            bank_reg <= cnt_reg[BANK_W-1:0];
          end
        end
        default: begin
          ack_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_wb_ram_bridge.sv
// Directed bench for mpu_wb_ram_bridge with default parameters (2 banks of
// 4096 x 32). A behavioural synchronous RAM per bank is preloaded with
// 0xC0DE_<word index>; expected read data are hand-derived constants.
module tb_mpu_wb_ram_bridge;
  import mpu_wb_ram_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [14:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic        wb_ack_o;
  logic [23:0] ram_adr_o;
  logic [63:0] ram_dat_o;
  logic [63:0] ram_dat_i;
  logic [7:0]  ram_we_o;
`ifdef MPU_WB_RAM_WINDOW_EN
  logic [63:0] win_dat_o;
  logic        win_valid_o;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 sys_clk = ~sys_clk;

  mpu_wb_ram_bridge dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_i  (wb_sel_i),
    .wb_we_i   (wb_we_i),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_cti_i  (wb_cti_i),
    .wb_ack_o  (wb_ack_o),
    .ram_adr_o (ram_adr_o),
    .ram_dat_o (ram_dat_o),
    .ram_dat_i (ram_dat_i),
    .ram_we_o  (ram_we_o)
`ifdef MPU_WB_RAM_WINDOW_EN
    ,
    .win_dat_o   (win_dat_o),
    .win_valid_o (win_valid_o)
`endif
  );

  // Behavioural banked RAM: byte writes, one-cycle registered read (old data on collision)
  logic        mem_init;
  logic [31:0] mem [2][4096];
  logic [31:0] rd  [2];

  always @(posedge sys_clk) begin
    for (int b = 0; b < 2; b++) begin
      if (mem_init) begin
        for (int a = 0; a < 4096; a++) mem[b][a] <= {16'hC0DE, 16'(a * 2 + b)};
      end else begin
        for (int k = 0; k < 4; k++)
          if (ram_we_o[b*4+k]) mem[b][ram_adr_o[b*12 +: 12]][k*8 +: 8] <= ram_dat_o[b*32+k*8 +: 8];
      end
      rd[b] <= mem[b][ram_adr_o[b*12 +: 12]];
    end
  end
  assign ram_dat_i = {rd[1], rd[0]};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Memory contents after the directed writes below
  function automatic logic [31:0] exp_word(input int w);
    case (w)
      1:       return 32'hDEADBEEF;
      2:       return 32'hC0DE00AA;
      3:       return 32'h12340003;
      default: return {16'hC0DE, 16'(w)};
    endcase
  endfunction

  task automatic bus_idle();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_cti_i = CTI_CLASSIC; wb_sel_i = 4'h0;
  endtask

  // Incrementing read burst; exp_adr1 = rows expected while the first beat is acked
  task automatic run_burst(input logic [14:0] adr, input int len, input logic [23:0] exp_adr1);
    int w;
    w = int'(adr[14:2]);
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr; wb_cti_i = CTI_INCR;
    @(negedge sys_clk);
    check("burst_req_ack", wb_ack_o, 1'b0);
    for (int i = 0; i < len; i++) begin
      @(posedge sys_clk); #1;
      wb_cti_i = (i == len - 1) ? CTI_END : CTI_INCR;
      @(negedge sys_clk);
      check("burst_ack", wb_ack_o, 1'b1);
      check("burst_dat", wb_dat_o, exp_word((w + i) & 32'h1FFF));
      if (i == 0) check("burst_row", ram_adr_o, exp_adr1);
    end
    @(posedge sys_clk); #1;
    bus_idle();
    @(negedge sys_clk);
    check("burst_end_ack", wb_ack_o, 1'b0);
    $display("burst adr=0x%04h len=%0d last_dat=0x%08h", adr, len, wb_dat_o);
  endtask

  typedef struct {
    logic        we;
    logic [14:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [7:0]  exp_we;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat;

    vecs[0] = '{1'b0, 15'h0004, 32'h0,        4'h0, 8'h00, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 15'h0008, 32'h000000AA, 4'h1, 8'h01, 32'h0};
    vecs[2] = '{1'b0, 15'h0008, 32'h0,        4'h0, 8'h00, 32'hC0DE00AA};
    vecs[3] = '{1'b0, 15'h0000, 32'h0,        4'h0, 8'h00, 32'hC0DE0000};
    vecs[4] = '{1'b1, 15'h000C, 32'h12345678, 4'hC, 8'hC0, 32'h0};
    vecs[5] = '{1'b0, 15'h000C, 32'h0,        4'h0, 8'h00, 32'h12340003};
    vecs[6] = '{1'b0, 15'h7FFC, 32'h0,        4'h0, 8'h00, 32'hC0DE1FFF};
    vecs[7] = '{1'b0, 15'h0006, 32'h0,        4'h0, 8'h00, 32'hDEADBEEF};

    // Reset with a live write strobe: nothing may be written or acked
    sys_rst = 1'b1; mem_init = 1'b1;
    wb_adr_i = 15'h0004; wb_dat_i = 32'hFFFFFFFF; wb_sel_i = 4'hF;
    wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_cti_i = CTI_CLASSIC;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_ack", wb_ack_o, 1'b0);
    check("rst_we", ram_we_o, 8'h00);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0; mem_init = 1'b0;
    bus_idle();
    @(negedge sys_clk);
    check("idle_ack", wb_ack_o, 1'b0);
    $display("reset done");

    // Write 0xDEADBEEF to word 1 (bank1 row0)
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 15'h0004; wb_dat_i = 32'hDEADBEEF; wb_sel_i = 4'hF;
    @(negedge sys_clk);
    check("w1_we", ram_we_o, 8'hF0);
    check("w1_dat", ram_dat_o, 64'hDEADBEEF_DEADBEEF);
`ifdef MPU_WB_RAM_WINDOW_EN
    check("w1_row", ram_adr_o, 24'h000001);
`else
    check("w1_row", ram_adr_o, 24'h000000);
`endif
    check("w1_req_ack", wb_ack_o, 1'b0);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("w1_ack", wb_ack_o, 1'b1);
    check("w1_ack_we", ram_we_o, 8'h00);
    @(posedge sys_clk); #1;
    bus_idle();
    @(negedge sys_clk);
    check("w1_end_ack", wb_ack_o, 1'b0);
    $display("write adr=0x0004 dat=0xdeadbeef sel=f");

    // Table of classic accesses
    for (int v = 0; v < 8; v++) begin
      @(posedge sys_clk); #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = vecs[v].we;
      wb_adr_i = vecs[v].adr; wb_dat_i = vecs[v].dat; wb_sel_i = vecs[v].sel;
      wb_cti_i = CTI_CLASSIC;
      @(negedge sys_clk);
      check("vec_req_we", ram_we_o, vecs[v].exp_we);
      check("vec_req_ack", wb_ack_o, 1'b0);
      lat = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        lat++;
        if (wb_ack_o) break;
      end
      check("vec_ack_latency", lat, 1);
      check("vec_ack_we", ram_we_o, 8'h00);
      if (!vecs[v].we) check("vec_rdata", wb_dat_o, vecs[v].exp_dat);
      $display("vec %0d %s adr=0x%04h dat=0x%08h ack_lat=%0d", v, vecs[v].we ? "write" : "read ",
               vecs[v].adr, vecs[v].we ? vecs[v].dat : wb_dat_o, lat);
      @(posedge sys_clk); #1;
      bus_idle();
      @(negedge sys_clk);
      check("vec_end_ack", wb_ack_o, 1'b0);
    end

    // Bursts: from word 0, and wrapping from the last word
`ifdef MPU_WB_RAM_WINDOW_EN
    run_burst(15'h0000, 4, 24'h000001);
`else
    run_burst(15'h0000, 4, 24'h000000);
`endif
    run_burst(15'h7FFC, 2, 24'h000000);

    // Strobe dropped mid-burst: no ack, next access starts from IDLE
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 15'h0010; wb_cti_i = CTI_INCR;
    @(negedge sys_clk);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("drop_first_ack", wb_ack_o, 1'b1);
    check("drop_first_dat", wb_dat_o, 32'hC0DE0004);
    @(posedge sys_clk); #1;
    wb_stb_i = 1'b0;
    @(negedge sys_clk);
    check("drop_ack", wb_ack_o, 1'b0);
    @(posedge sys_clk); #1;
    wb_stb_i = 1'b1; wb_adr_i = 15'h0020; wb_cti_i = CTI_CLASSIC;
    @(negedge sys_clk);
    check("drop_next_req_ack", wb_ack_o, 1'b0);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("drop_next_ack", wb_ack_o, 1'b1);
    check("drop_next_dat", wb_dat_o, 32'hC0DE0008);
    @(posedge sys_clk); #1;
    bus_idle();
    $display("burst stb drop then read adr=0x0020 dat=0x%08h", wb_dat_o);

    // Reset during a burst ack cycle, with a write presented while still in reset
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 15'h0008; wb_cti_i = CTI_INCR;
    @(negedge sys_clk);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("rstb_ack", wb_ack_o, 1'b1);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rstb_we", ram_we_o, 8'h00);
    @(posedge sys_clk); #1;
    wb_we_i = 1'b1; wb_adr_i = 15'h0000; wb_dat_i = 32'h00000BAD; wb_sel_i = 4'hF;
    wb_cti_i = CTI_CLASSIC;
    @(negedge sys_clk);
    check("rstb_ack_drop", wb_ack_o, 1'b0);
    check("rstb_wr_we", ram_we_o, 8'h00);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0; wb_we_i = 1'b0; wb_sel_i = 4'h0;
    @(negedge sys_clk);
    check("rstb_req_ack", wb_ack_o, 1'b0);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("rstb_read_ack", wb_ack_o, 1'b1);
    check("rstb_read_dat", wb_dat_o, 32'hC0DE0000);
    @(posedge sys_clk); #1;
    bus_idle();
    $display("reset mid-burst then read adr=0x0000 dat=0x%08h", wb_dat_o);

`ifdef MPU_WB_RAM_WINDOW_EN
    // Wide window read from word 3: banks hold words 3 and 4
    @(posedge sys_clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 15'h000C; wb_cti_i = CTI_CLASSIC;
    @(negedge sys_clk);
    check("win_row", ram_adr_o, 24'h001002);
    check("win_req_valid", win_valid_o, 1'b0);
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    check("win_valid", win_valid_o, 1'b1);
    check("win_dat", win_dat_o, 64'hC0DE0004_12340003);
    check("win_wb_dat", wb_dat_o, 32'h12340003);
    @(posedge sys_clk); #1;
    bus_idle();
    $display("window read adr=0x000c win=0x%016h", win_dat_o);
`endif

    repeat (2) @(posedge sys_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
